saturn_sram_ctrl: RTL and testbench

- Nibble-wide external asynchronous SRAM controller.
- Sits directly downstream of saturn_core: it replaces the tied-high mem_ack_in with a real acknowledge, and it drives the addr_o/oe_o/we_o/data_io pins of saturn_top.
- Converts single-cycle core requests into timed SRAM read/write cycles with programmable wait states.
- Guarantees bus turnaround so the FPGA and the SRAM never drive data at the same time.

---
 rtl/saturn_sram_ctrl.sv | 166 ++++++++++++++++
 tb/tb_saturn_sram_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/saturn_sram_ctrl.sv
// Nibble-wide asynchronous SRAM controller for saturn_core: turns single-cycle
// core requests into timed SRAM read/write cycles with programmable wait states.
module saturn_sram_ctrl #(
    parameter int unsigned RD_WAIT  = 2,
    parameter int unsigned WR_SETUP = 1,
    parameter int unsigned WR_PULSE = 2,
    parameter int unsigned WR_HOLD  = 1
) (
    input  logic        clk_in,
    input  logic        reset_n_in,
    input  logic        req_in,
    input  logic        we_in,
    input  logic [19:0] addr_in,
    input  logic [3:0]  data_in,
    output logic [3:0]  data_o,
    output logic        ack_o,
    output logic        busy_o,
    output logic [19:0] sram_addr_o,
    output logic        sram_oe_n_o,
    output logic        sram_we_n_o,
    output logic [3:0]  sram_data_o,
    output logic        sram_data_oe_o,
    input  logic [3:0]  sram_data_in
);

    localparam int unsigned MAX_A = (RD_WAIT > WR_SETUP) ? RD_WAIT : WR_SETUP;
    localparam int unsigned MAX_B = (WR_PULSE > WR_HOLD) ? WR_PULSE : WR_HOLD;
    localparam int unsigned MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CW    = $clog2(MAX_P + 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WSET = 3'd2,
        WPUL = 3'd3,
        WHLD = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [3:0]  data_d;
    logic        ack_d;
    logic        busy_d;
    logic [19:0] sram_addr_d;
    logic        sram_oe_n_d;
    logic        sram_we_n_d;
    logic [3:0]  sram_data_d;
    logic        sram_data_oe_d;

    // State, counter and output registers; reset aborts any access in flight.
    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            data_o         <= '0;
            ack_o          <= 1'b0;
            busy_o         <= 1'b0;
            sram_addr_o    <= '0;
            sram_oe_n_o    <= 1'b1;
            sram_we_n_o    <= 1'b1;
            sram_data_o    <= '0;
            sram_data_oe_o <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            data_o         <= data_d;
            ack_o          <= ack_d;
            busy_o         <= busy_d;
            sram_addr_o    <= sram_addr_d;
            sram_oe_n_o    <= sram_oe_n_d;
            sram_we_n_o    <= sram_we_n_d;
            sram_data_o    <= sram_data_d;
            sram_data_oe_o <= sram_data_oe_d;
        end
    end

    // Next-state and wait counter. The read counter starts at RD_WAIT so the
    // sample edge lands RD_WAIT+1 edges after the request was taken.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_in) begin
                    if (we_in) begin
                        state_d = WSET;
                        cnt_d   = CW'(WR_SETUP - 1);
                    end else begin
                        state_d = RD;
                        cnt_d   = CW'(RD_WAIT);
                    end
                end
            end
            RD: begin
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            WSET: begin
                if (cnt_q == '0) begin
                    state_d = WPUL;
                    cnt_d   = CW'(WR_PULSE - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            WPUL: begin
                if (cnt_q == '0) begin
                    state_d = WHLD;
                    cnt_d   = CW'(WR_HOLD - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            WHLD: begin
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs; everything holds unless changed.
    always_comb begin
        data_d         = data_o;
        ack_d          = 1'b0;
        busy_d         = (state_d != IDLE);
        sram_addr_d    = sram_addr_o;
        sram_oe_n_d    = sram_oe_n_o;
        sram_we_n_d    = sram_we_n_o;
        sram_data_d    = sram_data_o;
        sram_data_oe_d = sram_data_oe_o;
        case (state_q)
            IDLE: begin
                if (req_in) begin
                    sram_addr_d = addr_in;
                    if (we_in) begin
                        sram_data_d    = data_in;
                        sram_data_oe_d = 1'b1;
                    end else begin
                        sram_oe_n_d = 1'b0;
                    end
                end
            end
            RD: begin
                if (cnt_q == '0) begin
                    data_d      = sram_data_in;
                    sram_oe_n_d = 1'b1;
                    ack_d       = 1'b1;
                end
            end
            WSET: if (cnt_q == '0) sram_we_n_d = 1'b0;
            WPUL: if (cnt_q == '0) sram_we_n_d = 1'b1;
            WHLD: begin
                if (cnt_q == '0) begin
                    sram_data_oe_d = 1'b0;
                    ack_d          = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_saturn_sram_ctrl.sv
// Directed bench for saturn_sram_ctrl: default-timing instance plus a 1/1/1/1
// instance exercised with random accesses against a reference memory.
module tb_saturn_sram_ctrl;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic reset_n_in;

    logic        req0, we0, ack0, busy0, oe_n0, we_n0, doe0;
    logic [19:0] addr0, saddr0;
    logic [3:0]  din0, dout0, sdo0, sdi0;

    logic        req1, we1, ack1, busy1, oe_n1, we_n1, doe1;
    logic [19:0] addr1, saddr1;
    logic [3:0]  din1, dout1, sdo1, sdi1;

    int checks = 0;
    int errors = 0;

    logic [3:0] mem0 [logic [19:0]];
    logic [3:0] mem1 [logic [19:0]];
    logic [3:0] ref1 [logic [19:0]];

    saturn_sram_ctrl dut0 (
        .clk_in(clk_in), .reset_n_in(reset_n_in), .req_in(req0), .we_in(we0),
        .addr_in(addr0), .data_in(din0), .data_o(dout0), .ack_o(ack0),
        .busy_o(busy0), .sram_addr_o(saddr0), .sram_oe_n_o(oe_n0),
        .sram_we_n_o(we_n0), .sram_data_o(sdo0), .sram_data_oe_o(doe0),
        .sram_data_in(sdi0)
    );

    saturn_sram_ctrl #(.RD_WAIT(1), .WR_SETUP(1), .WR_PULSE(1), .WR_HOLD(1)) dut1 (
        .clk_in(clk_in), .reset_n_in(reset_n_in), .req_in(req1), .we_in(we1),
        .addr_in(addr1), .data_in(din1), .data_o(dout1), .ack_o(ack1),
        .busy_o(busy1), .sram_addr_o(saddr1), .sram_oe_n_o(oe_n1),
        .sram_we_n_o(we_n1), .sram_data_o(sdo1), .sram_data_oe_o(doe1),
        .sram_data_in(sdi1)
    );

    function automatic logic [3:0] peek0(input logic [19:0] a);
        if (mem0.exists(a)) return mem0[a];
        return 4'h0;
    endfunction

    function automatic logic [3:0] peek1(input logic [19:0] a);
        if (mem1.exists(a)) return mem1[a];
        return 4'h0;
    endfunction

    function automatic logic [3:0] peek_ref(input logic [19:0] a);
        if (ref1.exists(a)) return ref1[a];
        return 4'h0;
    endfunction

    function automatic bit inv_bad(input logic oe_n, input logic doe, input logic we_n,
                                   input logic wp, input logic [19:0] sa, input logic [19:0] wa);
        return (oe_n === 1'b0 && doe === 1'b1) ||
               (we_n === 1'b0 && (doe !== 1'b1 || (wp === 1'b0 && sa !== wa)));
    endfunction

    // SRAM pin models and bus invariants, evaluated mid-cycle. A write commits
    // when we_n rises while the FPGA still drives the bus.
    logic        wp0 = 1'b1, wp1 = 1'b1;
    logic [19:0] wa0 = '0, wa1 = '0;
    always @(negedge clk_in) begin
        checks += 2;
        if (inv_bad(oe_n0, doe0, we_n0, wp0, saddr0, wa0)) begin
            errors++;
            $display("FAIL invariant0: oe_n=%b data_oe=%b we_n=%b addr=%h required no contention, we_n low only with stable driven bus",
                     oe_n0, doe0, we_n0, saddr0);
        end
        if (inv_bad(oe_n1, doe1, we_n1, wp1, saddr1, wa1)) begin
            errors++;
            $display("FAIL invariant1: oe_n=%b data_oe=%b we_n=%b addr=%h required no contention, we_n low only with stable driven bus",
                     oe_n1, doe1, we_n1, saddr1);
        end
        if (wp0 === 1'b0 && we_n0 === 1'b1 && doe0 === 1'b1) mem0[saddr0] = sdo0;
        if (wp1 === 1'b0 && we_n1 === 1'b1 && doe1 === 1'b1) mem1[saddr1] = sdo1;
        wp0 = we_n0; wa0 = saddr0;
        wp1 = we_n1; wa1 = saddr1;
        sdi0 = (oe_n0 === 1'b0) ? peek0(saddr0) : 4'h0;
        sdi1 = (oe_n1 === 1'b0) ? peek1(saddr1) : 4'h0;
    end

    task automatic tick();
        @(negedge clk_in);
    endtask

    task automatic test_reset();
        reset_n_in = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 20'h12345; din0 = 4'h0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; din1 = 4'h0;
        repeat (3) tick();
        checks++;
        if ({ack0, busy0, oe_n0, we_n0, doe0, saddr0, sdo0, dout0} !==
            {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 20'h0, 4'h0, 4'h0}) begin
            errors++;
            $display("FAIL reset0: ack=%b busy=%b oe_n=%b we_n=%b doe=%b addr=%h sdo=%h dout=%h required 0 0 1 1 0 00000 0 0",
                     ack0, busy0, oe_n0, we_n0, doe0, saddr0, sdo0, dout0);
        end
        checks++;
        if ({ack1, busy1, oe_n1, we_n1, doe1, saddr1, sdo1, dout1} !==
            {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 20'h0, 4'h0, 4'h0}) begin
            errors++;
            $display("FAIL reset1: ack=%b busy=%b oe_n=%b we_n=%b doe=%b addr=%h required reset values",
                     ack1, busy1, oe_n1, we_n1, doe1, saddr1);
        end
        req0 = 1'b0;
        reset_n_in = 1'b1;
        tick();
    endtask

    task automatic test_read();
        mem0[20'h00123] = 4'hA;
        req0 = 1'b1; we0 = 1'b0; addr0 = 20'h00123;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (oe_n0 !== 1'(k >= 3) || ack0 !== 1'(k == 3) || busy0 !== 1'(k <= 3) ||
                doe0 !== 1'b0 || saddr0 !== 20'h00123) begin
                errors++;
                $display("FAIL read_k%0d: oe_n=%b ack=%b busy=%b doe=%b addr=%h required %b %b %b 0 00123",
                         k, oe_n0, ack0, busy0, doe0, saddr0, 1'(k >= 3), 1'(k == 3), 1'(k <= 3));
            end
            if (k == 1) addr0 = 20'hFFFFF;
            if (k >= 3) begin
                checks++;
                if (dout0 !== 4'hA) begin
                    errors++;
                    $display("FAIL read_data_k%0d: data=%h required a", k, dout0);
                end
                req0 = 1'b0;
            end
        end
    endtask

    task automatic test_write();
        req0 = 1'b1; we0 = 1'b1; addr0 = 20'h2E100; din0 = 4'h5;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (doe0 !== 1'(k <= 3) || we_n0 !== 1'(!(k == 1 || k == 2)) ||
                ack0 !== 1'(k == 4) || busy0 !== 1'(k <= 4) || oe_n0 !== 1'b1 ||
                saddr0 !== 20'h2E100 || sdo0 !== 4'h5) begin
                errors++;
                $display("FAIL write_k%0d: doe=%b we_n=%b ack=%b busy=%b oe_n=%b addr=%h sdo=%h required %b %b %b %b 1 2e100 5",
                         k, doe0, we_n0, ack0, busy0, oe_n0, saddr0, sdo0,
                         1'(k <= 3), 1'(!(k == 1 || k == 2)), 1'(k == 4), 1'(k <= 4));
            end
            if (k == 1) begin addr0 = 20'h00000; din0 = 4'hF; end
            if (k == 4) req0 = 1'b0;
        end
        checks++;
        if (peek0(20'h2E100) !== 4'h5) begin
            errors++;
            $display("FAIL write_mem: mem[2e100]=%h required 5", peek0(20'h2E100));
        end
    endtask

    task automatic test_back_to_back();
        int n;
        mem0[20'h2E100] = 4'h0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 20'h2E100; din0 = 4'h5;
        n = 0;
        do begin tick(); n++; end while (ack0 !== 1'b1 && n < 20);
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL b2b_write_latency: ack after %0d cycles required 5", n);
        end
        checks++;
        if (doe0 !== 1'b0 || oe_n0 !== 1'b1 || we_n0 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_write_done: doe=%b oe_n=%b we_n=%b required 0 1 1", doe0, oe_n0, we_n0);
        end
        we0 = 1'b0;
        n = 0;
        do begin
            tick(); n++;
            if (n == 1 || n == 2) begin
                checks++;
                if (busy0 !== 1'(n == 2)) begin
                    errors++;
                    $display("FAIL b2b_gap_n%0d: busy=%b required %b", n, busy0, 1'(n == 2));
                end
            end
        end while (ack0 !== 1'b1 && n < 20);
        checks++;
        if (n != 5 || dout0 !== 4'h5) begin
            errors++;
            $display("FAIL b2b_read: ack after %0d cycles data=%h required 5 cycles data 5", n, dout0);
        end
        checks++;
        if (doe0 !== 1'b0 || oe_n0 !== 1'b1 || we_n0 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_read_done: doe=%b oe_n=%b we_n=%b required 0 1 1", doe0, oe_n0, we_n0);
        end
        req0 = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_write();
        mem0[20'h00777] = 4'h3;
        req0 = 1'b1; we0 = 1'b1; addr0 = 20'h00777; din0 = 4'hC;
        tick();
        tick();
        checks++;
        if (we_n0 !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_pulse: we_n=%b required 0", we_n0);
        end
        reset_n_in = 1'b0;
        tick();
        checks++;
        if (we_n0 !== 1'b1 || doe0 !== 1'b0 || busy0 !== 1'b0 || ack0 !== 1'b0 || oe_n0 !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_abort: we_n=%b doe=%b busy=%b ack=%b oe_n=%b required 1 0 0 0 1",
                     we_n0, doe0, busy0, ack0, oe_n0);
        end
        reset_n_in = 1'b1;
        req0 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (ack0 !== 1'b0 || busy0 !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_noack_k%0d: ack=%b busy=%b required 0 0", k, ack0, busy0);
            end
        end
        checks++;
        if (peek0(20'h00777) !== 4'h3) begin
            errors++;
            $display("FAIL rst_mid_mem: mem[00777]=%h required 3", peek0(20'h00777));
        end
    endtask

    task automatic test_req_drop();
        int acks = 0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 20'h00123;
        tick();
        req0 = 1'b0;
        for (int k = 1; k < 10; k++) begin
            tick();
            if (ack0 === 1'b1) acks++;
            checks++;
            if (ack0 !== 1'(k == 3) || busy0 !== 1'(k <= 3)) begin
                errors++;
                $display("FAIL req_drop_k%0d: ack=%b busy=%b required %b %b",
                         k, ack0, busy0, 1'(k == 3), 1'(k <= 3));
            end
        end
        checks++;
        if (acks != 1 || dout0 !== 4'hA || oe_n0 !== 1'b1) begin
            errors++;
            $display("FAIL req_drop_total: acks=%0d data=%h oe_n=%b required 1 a 1", acks, dout0, oe_n0);
        end
    endtask

    task automatic test_sweep();
        logic        w;
        logic [19:0] a;
        logic [3:0]  d;
        int          n, exp_n;
        for (int i = 0; i < 1000; i++) begin
            w = 1'($urandom_range(0, 1));
            a = 20'hB0000 | 20'($urandom_range(0, 15));
            d = 4'($urandom);
            req1 = 1'b1; we1 = w; addr1 = a; din1 = d;
            exp_n = w ? 4 : 3;
            n = 0;
            do begin
                tick(); n++;
                if (n == 1) begin
                    req1 = 1'($urandom); we1 = 1'($urandom);
                    addr1 = 20'($urandom); din1 = 4'($urandom);
                end
            end while (ack1 !== 1'b1 && n < 20);
            req1 = 1'b0;
            checks++;
            if (n != exp_n) begin
                errors++;
                $display("FAIL sweep_latency_%0d: we=%b ack after %0d cycles required %0d", i, w, n, exp_n);
            end
            if (w) begin
                ref1[a] = d;
            end else begin
                checks++;
                if (dout1 !== peek_ref(a)) begin
                    errors++;
                    $display("FAIL sweep_read_%0d: addr=%h data=%h required %h", i, a, dout1, peek_ref(a));
                end
            end
            tick();
            checks++;
            if (busy1 !== 1'b0 || ack1 !== 1'b0) begin
                errors++;
                $display("FAIL sweep_idle_%0d: busy=%b ack=%b required 0 0", i, busy1, ack1);
            end
        end
        for (int j = 0; j < 16; j++) begin
            a = 20'hB0000 | 20'(j);
            checks++;
            if (peek1(a) !== peek_ref(a)) begin
                errors++;
                $display("FAIL sweep_mem_%h: sram=%h required %h", a, peek1(a), peek_ref(a));
            end
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_reset_mid_write();
        test_req_drop();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
